mux_n_1_rr_stream: RTL and testbench
====================================

MUX_N_1_RR_STREAM -- requirements
Module: mux_n_1_rr_stream

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, giving the data width per channel in bits (legal range >= 1).
REQ-002 The module SHALL have parameter N_CH, default 4, giving the number of input channels (legal range 2..16).
REQ-003 The module SHALL have parameter SEL_W, default $clog2(N_CH), giving the channel index width.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 Port in_valid, input, N_CH bits: bit i high means channel i presents data.
REQ-007 Port in_data, input, N_CH*WIDTH bits: channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 Port in_ready, output, N_CH bits: bit i high means channel i's data is accepted this cycle.
REQ-009 Port mode, input, 1 bit: 0 selects fixed-select mode, 1 selects round-robin mode.
REQ-010 Port sel, input, SEL_W bits: channel index used in fixed-select mode.
REQ-011 Port out_valid, output, 1 bit: the output register holds a word.
REQ-012 Port out_data, output, WIDTH bits: the registered word.
REQ-013 Port out_ch, output, SEL_W bits: source channel of out_data.
REQ-014 Port out_ready, input, 1 bit: downstream accepts the word when out_ready and out_valid are both high.

Function
REQ-015 The output stage SHALL be a single register stage with free = !out_valid || out_ready; latency from input acceptance to out_valid SHALL be 1 cycle, and throughput SHALL be 1 word/cycle.
REQ-016 In fixed mode, grant = sel and has_grant = in_valid[sel] && (sel < N_CH); sel >= N_CH SHALL yield no grant.
REQ-017 In round-robin mode, grant SHALL be the first index i with in_valid[i] high, searching ptr, ptr+1, ... N_CH-1, 0, ... ptr-1; has_grant = |in_valid.
REQ-018 in_ready[i] SHALL be (i == grant) && has_grant && free; at most one in_ready bit SHALL be high per cycle.
REQ-019 A transfer (has_grant && free) SHALL load in_data[grant], grant into out_data and out_ch, and set out_valid = 1.
REQ-020 Output drain without a transfer (out_valid && out_ready && !has_grant) SHALL clear out_valid; out_data and out_ch SHALL hold their values.
REQ-021 While out_valid && !out_ready, out_valid, out_data and out_ch SHALL remain stable, and all in_ready bits SHALL be 0.
REQ-022 ptr (SEL_W bits) SHALL update to (grant+1) mod N_CH only on a round-robin-mode transfer; it SHALL wrap from N_CH-1 to 0, including for non-power-of-2 N_CH.
REQ-023 Fixed-mode transfers SHALL NOT modify ptr.
REQ-024 mode and sel SHALL be evaluated combinationally each cycle; a change SHALL take effect in the same cycle with no flush of the output register.
REQ-025 Simultaneous drain and load in the same cycle SHALL keep out_valid = 1 with the new word, with no bubble.
REQ-026 The data-path selection SHALL be a pure N_CH:1 mux of WIDTH bits; no data bit SHALL be altered.

Reset
REQ-027 When rst_n = 0 at a clock edge, out_valid, out_data and out_ch SHALL be set to 0 and ptr SHALL be set to 0, regardless of any in-flight transfer.
REQ-028 While rst_n = 0, all in_ready bits SHALL be 0.
REQ-029 On the first cycle after rst_n returns to 1, round-robin priority SHALL start at channel 0.

Verification
REQ-030 Reset: hold rst_n = 0 for 2 cycles with all in_valid high -> out_valid = 0, out_data = 0, out_ch = 0, in_ready = 0.
REQ-031 Round-robin fairness: N_CH = 4, mode = 1, in_valid = 4'b1111, out_ready = 1, in_data = 3,5,A,C -> out_ch sequence is 0,1,2,3,0 and out_data sequence is 3,5,A,C,3 on consecutive cycles.
REQ-032 Skip and wrap: mode = 1, ptr = 3, in_valid = 4'b0101 -> grant = 0 and ptr becomes 1; on the next transfer grant = 2 and ptr becomes 3.
REQ-033 Backpressure: out_valid = 1, out_ready = 0 for 3 cycles -> out_data/out_ch stable and in_ready = 0; raise out_ready -> a new word is loaded in that same cycle with no bubble.
REQ-034 Fixed mode: mode = 0, sel = 2, in_valid = 4'b1111 -> only in_ready[2] is high and every output word has out_ch = 2; sel = 5 with N_CH = 4 (SEL_W widened by test) -> no transfer.
REQ-035 Mid-operation reset: assert rst_n = 0 while out_valid = 1 and out_ready = 0 -> next cycle out_valid = 0, and after release the first grant goes to the lowest-index valid channel.

Source files
------------

// File: rtl/mux_n_1_rr_stream.sv
// N_CH:1 stream multiplexer with a single registered output stage.
// Channel choice is either a fixed index (sel) or round-robin from a rotating pointer.
module mux_n_1_rr_stream #(
    parameter int WIDTH = 4,
    parameter int N_CH  = 4,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       in_valid,
    input  logic [N_CH*WIDTH-1:0] in_data,
    output logic [N_CH-1:0]       in_ready,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_ch,
    input  logic                  out_ready
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_ch_q, out_ch_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic             free;
    logic             fix_hit;
    logic             rr_hi_found;
    logic [SEL_W-1:0] rr_hi_idx;
    logic [SEL_W-1:0] rr_lo_idx;
    logic [SEL_W-1:0] grant;
    logic             has_grant;
    logic             transfer;
    logic [WIDTH-1:0] mux_data;

    assign free = !out_valid_q || out_ready;

    // Out-of-range sel matches no channel, so it never grants.
    always_comb begin
        fix_hit = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (int'(sel) == i) begin
                fix_hit = in_valid[i];
            end
        end
    end

    // Lowest valid index at or above ptr wins; otherwise wrap to the lowest valid index.
    always_comb begin
        rr_hi_found = 1'b0;
        rr_hi_idx   = '0;
        rr_lo_idx   = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                rr_lo_idx = SEL_W'(i);
                if (i >= int'(ptr_q)) begin
                    rr_hi_found = 1'b1;
                    rr_hi_idx   = SEL_W'(i);
                end
            end
        end
    end

    always_comb begin
        if (mode) begin
            grant     = rr_hi_found ? rr_hi_idx : rr_lo_idx;
            has_grant = |in_valid;
        end else begin
            grant     = sel;
            has_grant = fix_hit;
        end
    end

    assign transfer = rst_n && has_grant && free;

    always_comb begin
        mux_data = '0;
        in_ready = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (int'(grant) == i) begin
                mux_data    = in_data[i*WIDTH +: WIDTH];
                in_ready[i] = transfer;
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        if (transfer) begin
            out_valid_d = 1'b1;
            out_data_d  = mux_data;
            out_ch_d    = grant;
            if (mode) begin
                ptr_d = (int'(grant) == N_CH - 1) ? '0 : grant + SEL_W'(1);
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_n_1_rr_stream.sv
// Scoreboard bench for mux_n_1_rr_stream: a queue-based model predicts in_ready
// and the output word stream; a separate monitor compares the registered output.
module tb_mux_n_1_rr_stream;

    localparam int W  = 4;
    localparam int N  = 4;
    localparam int SW = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    in_valid;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_ready;
    logic            mode;
    logic [SW-1:0]   sel;
    logic            out_valid;
    logic [W-1:0]    out_data;
    logic [SW-1:0]   out_ch;
    logic            out_ready;

    mux_n_1_rr_stream #(.WIDTH(W), .N_CH(N), .SEL_W(SW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int d;
        int ch;
    } word_t;

    word_t sb[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    m_ptr    = 0;
    bit    pend_rst = 1'b1;
    bit    pend_xfer = 1'b0;
    word_t pend_w;
    int    pend_ptr;
    bit    last_rst = 1'b0;
    bit    init_done = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference arbitration: rotating search over (ptr + k) mod N.
    function automatic void model_grant(input logic [N-1:0] v, input logic m, input int s,
                                        input int p, output bit hg, output int g);
        hg = 1'b0;
        g  = 0;
        if (!m) begin
            g  = s;
            hg = (s < N) ? v[s] : 1'b0;
        end else begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (p + k) % N;
                if (!hg && v[idx]) begin
                    hg = 1'b1;
                    g  = idx;
                end
            end
        end
    endfunction

    // Model: decide at the negedge from stable inputs, commit at the following posedge.
    always @(negedge clk) begin
        bit hg;
        int g;
        bit free;
        int exp_ready;
        if (!rst_n) begin
            chk("in_ready_in_reset", int'(in_ready), 0);
            pend_rst  = 1'b1;
            pend_xfer = 1'b0;
        end else if (init_done) begin
            free = (sb.size() == 0) || out_ready;
            model_grant(in_valid, mode, int'(sel), m_ptr, hg, g);
            exp_ready = (hg && free) ? (1 << g) : 0;
            chk("in_ready", int'(in_ready), exp_ready);
            if (hg && free) begin
                pend_xfer = 1'b1;
                pend_w.d  = int'(in_data[g*W +: W]);
                pend_w.ch = g;
                pend_ptr  = mode ? (g + 1) % N : m_ptr;
            end
        end
    end

    always @(posedge clk) begin
        last_rst = 1'b0;
        if (pend_rst) begin
            sb.delete();
            m_ptr     = 0;
            pend_rst  = 1'b0;
            last_rst  = 1'b1;
            init_done = 1'b1;
        end else if (pend_xfer) begin
            sb.push_back(pend_w);
            m_ptr     = pend_ptr;
            pend_xfer = 1'b0;
        end
    end

    // Monitor: compares the output register to the head of the scoreboard every cycle.
    always @(negedge clk) begin
        if (last_rst) begin
            chk("out_valid_after_reset", int'(out_valid), 0);
            chk("out_data_after_reset", int'(out_data), 0);
            chk("out_ch_after_reset", int'(out_ch), 0);
        end else if (init_done) begin
            chk("out_valid", int'(out_valid), (sb.size() != 0) ? 1 : 0);
            if (out_valid && sb.size() != 0) begin
                chk("out_data", int'(out_data), sb[0].d);
                chk("out_ch", int'(out_ch), sb[0].ch);
                if (out_ready && rst_n) begin
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic step(input logic [N-1:0] v, input logic m, input int s, input logic ordy,
                        input logic rst, input logic [N*W-1:0] d);
        in_valid  = v;
        mode      = m;
        sel       = SW'(s);
        out_ready = ordy;
        rst_n     = rst;
        in_data   = d;
        @(posedge clk);
        #1;
    endtask

    localparam logic [N*W-1:0] FAIR_DATA = {4'hC, 4'hA, 4'h5, 4'h3};

    initial begin
        // reset held two cycles with every channel requesting
        step(4'b1111, 1'b1, 0, 1'b1, 1'b0, FAIR_DATA);
        step(4'b1111, 1'b1, 0, 1'b1, 1'b0, FAIR_DATA);
        // round-robin fairness: 0,1,2,3,0 then two more to bring ptr to 3
        repeat (7) step(4'b1111, 1'b1, 0, 1'b1, 1'b1, FAIR_DATA);
        // skip and wrap from ptr 3 with channels 0 and 2 requesting
        repeat (3) step(4'b0101, 1'b1, 0, 1'b1, 1'b1, FAIR_DATA);
        // backpressure for three cycles, then release
        repeat (3) step(4'b1111, 1'b1, 0, 1'b0, 1'b1, FAIR_DATA);
        repeat (3) step(4'b1111, 1'b1, 0, 1'b1, 1'b1, FAIR_DATA);
        // fixed mode, in-range and out-of-range sel
        repeat (4) step(4'b1111, 1'b0, 2, 1'b1, 1'b1, FAIR_DATA);
        repeat (3) step(4'b1111, 1'b0, 5, 1'b1, 1'b1, FAIR_DATA);
        step(4'b0000, 1'b1, 0, 1'b1, 1'b1, FAIR_DATA);
        // mid-operation reset while stalled, then low-index priority after release
        step(4'b1000, 1'b1, 0, 1'b0, 1'b1, FAIR_DATA);
        step(4'b1000, 1'b1, 0, 1'b0, 1'b1, FAIR_DATA);
        step(4'b1111, 1'b1, 0, 1'b0, 1'b0, FAIR_DATA);
        repeat (3) step(4'b0110, 1'b1, 0, 1'b1, 1'b1, FAIR_DATA);
        for (int c = 0; c < 3000; c++) begin
            step(N'($urandom), 1'($urandom), int'($urandom_range(0, 5)),
                 ($urandom_range(0, 9) < 7), ($urandom_range(0, 99) != 0),
                 (N*W)'($urandom));
        end
        step(4'b0000, 1'b1, 0, 1'b1, 1'b1, '0);
        step(4'b0000, 1'b1, 0, 1'b1, 1'b1, '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
